// File: rtl/alu_pkg.sv
// Opcode constants and controller state encoding shared by the ALU issue
// controller and the ALU bench.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_EQ  = 4'b1010;
    localparam logic [3:0] OP_LT  = 4'b1011;
    localparam logic [3:0] OP_GT  = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_B,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Byte-stream, ALU-port and result handshake bundle of the ALU issue controller.
// slave is the controller's view, master is the surrounding environment.
interface alu_issue_ctrl_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] res_data;
    logic       res_err;
    logic       res_valid;
    logic       res_ready;

    modport master (
        output in_data, in_valid, alu_result, res_ready,
        input  in_ready, alu_op, alu_a, alu_b, res_data, res_err, res_valid
    );

    modport slave (
        input  in_data, in_valid, alu_result, res_ready,
        output in_ready, alu_op, alu_a, alu_b, res_data, res_err, res_valid
    );

endinterface

// File: rtl/alu_byte_timer.sv
// Gap timer between command and operand bytes: counts enabled cycles from a
// clear and flags the cycle on which the count reaches LIMIT-1.
module alu_byte_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Collects a two-byte ALU command, issues it to an external ALU, captures the
// result with divide-by-zero, illegal-opcode and operand-timeout protection.
//
//   state      | meaning
//   IDLE       | waiting for command byte {opcode, operand_a}
//   WAIT_B     | waiting for operand byte, gap timer running
//   ISSUE      | operands presented to the ALU
//   CAPTURE    | ALU result (or error code) registered
//   HOLD       | result offered until res_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 16,
    parameter logic [3:0] OPC_DIV     = OP_DIV,
    parameter logic [3:0] OPC_LAST    = OP_GT
) (
    input  logic clk,
    input  logic rst,
    alu_issue_ctrl_if.slave bus
);

    state_t     state;
    state_t     state_nxt;
    logic       xfer;
    logic       tmo_expired;
    logic       tmo_clear;
    logic       tmo_enable;
    logic [3:0] op_q;
    logic [3:0] a_q;

    assign xfer       = bus.in_valid && bus.in_ready;
    assign tmo_clear  = (state != ST_WAIT_B);
    assign tmo_enable = (state == ST_WAIT_B) && !xfer;

    alu_byte_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (xfer) state_nxt = ST_WAIT_B;
            ST_WAIT_B: begin
                if (xfer) begin
                    state_nxt = ST_ISSUE;
                end else if (tmo_expired) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_ISSUE:   state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_HOLD;
            ST_HOLD:    if (bus.res_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        case (state)
            ST_IDLE:   bus.in_ready  = 1'b1;
            ST_WAIT_B: bus.in_ready  = 1'b1;
            ST_HOLD:   bus.res_valid = 1'b1;
            default: begin
                bus.in_ready  = 1'b0;
                bus.res_valid = 1'b0;
            end
        endcase
    end

    // ALU port registers load only on the operand byte, so they keep the last
    // issued command while a new one is being collected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= 4'h0;
            a_q          <= 4'h0;
            bus.alu_op   <= 4'h0;
            bus.alu_a    <= 4'h0;
            bus.alu_b    <= 4'h0;
            bus.res_data <= 8'h00;
            bus.res_err  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && xfer) begin
                op_q <= bus.in_data[7:4];
                a_q  <= bus.in_data[3:0];
            end
            if ((state == ST_WAIT_B) && xfer) begin
                bus.alu_op <= op_q;
                bus.alu_a  <= a_q;
                bus.alu_b  <= bus.in_data[3:0];
            end else if ((state == ST_WAIT_B) && tmo_expired) begin
                bus.res_data <= 8'h00;
                bus.res_err  <= 1'b1;
            end
            if (state == ST_CAPTURE) begin
                if (op_q > OPC_LAST) begin
                    bus.res_data <= 8'h00;
                    bus.res_err  <= 1'b1;
                end else if ((op_q == OPC_DIV) && (bus.alu_b == 4'h0)) begin
                    bus.res_data <= 8'hFF;
                    bus.res_err  <= 1'b1;
                end else begin
                    bus.res_data <= bus.alu_result;
                    bus.res_err  <= 1'b0;
                end
            end
        end
    end

endmodule
